// File: rtl/spi_motor_rx.sv
// spi_motor_rx: oversampled SPI command receiver with frame length checking, echo output and optional watchdog.
// Define SPI_MOTOR_WDOG_EN to enable the WDOG_CYCLES command-loss watchdog.
module spi_motor_rx #(
  parameter int NUM_CH      = 2,
  parameter int CMD_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int WDOG_CYCLES = 2_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sck,
  input  logic                    sdi,
  input  logic                    load,
  output logic                    sdo,
  output logic [NUM_CH*CMD_W-1:0] cmd_out,
  output logic                    cmd_valid,
  output logic                    frame_err,
  output logic                    wdog_to
);
  localparam int N  = NUM_CH * CMD_W;
  localparam int CW = $clog2(N + 2);
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  state_t state, state_n;
  logic [2:0] sync [SYNC_STAGES];
  logic sck_s, sdi_s, load_s, sck_d, load_d;
  logic sck_rise, sck_fall, load_rise, load_fall;
  logic commit, reject;
  logic [CW-1:0] cnt;
  logic [N-1:0] rx, tx, cmd_reg;
  assign {sck_s, sdi_s, load_s} = sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_d;
  assign sck_fall  = ~sck_s & sck_d;
  assign load_rise = load_s & ~load_d;
  assign load_fall = ~load_s & load_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      sck_d  <= 1'b0;
      load_d <= 1'b0;
    end else begin
      sync[0] <= {sck, sdi, load};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      sck_d  <= sck_s;
      load_d <= load_s;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  always_comb begin
    state_n = state;
    commit  = 1'b0;
    reject  = 1'b0;
    unique case (state)
      IDLE:  state_n = load_rise ? SHIFT : IDLE;
      SHIFT: state_n = load_fall ? CHECK : SHIFT;
      CHECK: begin
        state_n = IDLE;
        commit  = cnt == CW'(N);
        reject  = cnt != '0 && cnt != CW'(N);
      end
      default: state_n = IDLE;
    endcase
  end
  // sck edges coinciding with the load rise fall in IDLE and are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      rx        <= '0;
      tx        <= '0;
      cmd_reg   <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_valid <= commit;
      frame_err <= reject;
      if (commit) cmd_reg <= rx;
      if (state == IDLE && load_rise) begin
        cnt <= '0;
        rx  <= '0;
        tx  <= cmd_out;
      end else if (state == SHIFT) begin
        if (sck_rise) begin
          rx <= N'({rx, sdi_s});
          if (cnt != CW'(N + 1)) cnt <= cnt + CW'(1);
        end
        if (sck_fall) tx <= tx << 1;
      end
    end
  end
  assign sdo = (state == SHIFT) & tx[N-1];
`ifdef SPI_MOTOR_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wcnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         wcnt <= '0;
    else if (commit)   wcnt <= '0;
    else if (!wdog_to) wcnt <= wcnt + WW'(1);
  end
  assign wdog_to = wcnt == WW'(WDOG_CYCLES);
`else
  assign wdog_to = 1'b0;
`endif
  assign cmd_out = wdog_to ? '0 : cmd_reg;
endmodule

// File: doc/spi_motor_rx.md
SPI_MOTOR_RX -- requirements
Module: spi_motor_rx

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of command channels per frame.
REQ-002 SHALL have parameter CMD_W, default 8, bits per channel command.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flip-flop stages on each asynchronous input.
REQ-004 SHALL have parameter WDOG_CYCLES, default 2_000_000, clk cycles without a good frame before timeout.
REQ-005 SHALL have port clk  input  1  system clock, the only clock; all flops clocked on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-007 SHALL have port sck  input  1  SPI serial clock from master, asynchronous, oversampled.
REQ-008 SHALL have port sdi  input  1  serial data in, MSB first.
REQ-009 SHALL have port load  input  1  frame enable; high for the whole frame.
REQ-010 SHALL have port sdo  output  1  serial echo of the last committed frame.
REQ-011 SHALL have port cmd_out  output  NUM_CH*CMD_W  committed commands, channel 0 in the MSBs.
REQ-012 SHALL have port cmd_valid  output  1  one-clk pulse on each commit.
REQ-013 SHALL have port frame_err  output  1  one-clk pulse on each rejected frame.
REQ-014 SHALL have port wdog_to  output  1  level, high while timed out.

Function
REQ-015 SHALL pass sck, sdi and load through SYNC_STAGES-deep synchronisers; edges are detected on the synchronised sck/load against a one-cycle-delayed copy.
REQ-016 SHALL implement FSM IDLE -> SHIFT on synchronised load rise; SHIFT -> CHECK on synchronised load fall; CHECK -> IDLE after one cycle.
REQ-017 SHALL, in SHIFT, shift synchronised sdi into a NUM_CH*CMD_W receive register on each synchronised sck rising edge, first bit landing in the channel-0 MSB.
REQ-018 SHALL count received bits in a counter saturating at NUM_CH*CMD_W+1.
REQ-019 SHALL ignore sck edges in IDLE and CHECK.
REQ-020 SHALL, in CHECK with count == NUM_CH*CMD_W, copy the receive register to cmd_out and pulse cmd_valid in that cycle. Latency from raw load fall to cmd_valid is SYNC_STAGES+2 clk cycles.
REQ-021 SHALL, in CHECK with count nonzero and != NUM_CH*CMD_W (short or long frame), pulse frame_err and leave cmd_out unchanged.
REQ-022 SHALL, in CHECK with count == 0, return to IDLE with no pulse.
REQ-023 SHALL, on SHIFT entry, load a transmit register with cmd_out. sdo drives its MSB. It shifts left, zero-filling, on each synchronised sck falling edge in SHIFT. sdo is 0 outside SHIFT.
REQ-024 SHALL require sck high and low times of at least SYNC_STAGES+1 clk cycles. Faster sck is out of specification, with no defined behaviour.
REQ-025 SHALL give a load rise and an sck edge detected in the same cycle load-edge priority; that sck edge is not sampled.

Reset
REQ-026 SHALL, on reset assertion, immediately set FSM=IDLE, bit count=0, receive/transmit registers=0, cmd_out=0, cmd_valid=0, frame_err=0, wdog_to=0, sdo=0, synchronisers=0.
REQ-027 SHALL discard a frame in progress on reset; after release, the next load rise starts a fresh frame.

Configuration
REQ-028 SHALL, with macro SPI_MOTOR_WDOG_EN defined, count clk cycles since the last cmd_valid (or reset).
REQ-029 SHALL, with SPI_MOTOR_WDOG_EN, set wdog_to and force cmd_out to 0 when the count reaches WDOG_CYCLES. Both hold until the next cmd_valid, which clears wdog_to and loads cmd_out normally.
REQ-030 SHALL, without SPI_MOTOR_WDOG_EN, omit the counter, tie wdog_to to 0, and hold cmd_out indefinitely.

Verification (NUM_CH=2, CMD_W=8, SYNC_STAGES=2, sck half-period 5 clk)
REQ-031 SHALL cover: frame 0xAA,0x55 (16 bits) -> cmd_out=16'hAA55, single cmd_valid pulse 4 clk after load fall, frame_err never high.
REQ-032 SHALL cover: second frame 8'd100,8'd50 -> sdo bits during the frame = 1010101001010101, then cmd_out=16'h6432.
REQ-033 SHALL cover: 15-bit frame, then 17-bit frame -> two frame_err pulses, no cmd_valid, cmd_out stays 16'h6432.
REQ-034 SHALL cover: reset asserted after bit 9 of a frame -> all outputs 0 immediately; next full frame 0x12,0x34 -> cmd_out=16'h1234.
REQ-035 SHALL cover: load pulsed with no sck edges -> no cmd_valid, no frame_err.
REQ-036 SHALL cover: SPI_MOTOR_WDOG_EN with WDOG_CYCLES=100, no frame for 100 cycles after a commit -> wdog_to=1, cmd_out=0; next good frame clears wdog_to.
